// File: rtl/jogador_pkg.sv
// Shared types and constants for the automatic memory-game player.
package jogador_pkg;

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    INICIA       = 4'd1,
    ESPERA_LED   = 4'd2,
    ESPERA_APAGA = 4'd3,
    PRESSIONA    = 4'd4,
    SOLTA        = 4'd5,
    NOVA         = 4'd6,
    FIM          = 4'd7,
    ERRO         = 4'd8
  } estado_t;

  // x^8+x^6+x^5+x^4+1, shifted left with feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;

  localparam int         MEM_DEPTH  = 16;
  localparam int         ADDR_W     = 4;
  localparam int         TIMER_W    = 16;
  localparam logic [3:0] RODADA_MAX = 4'd15;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/temporizador_jogador.sv
// Loadable down-counter; done_o is high whenever the count has reached zero.
module temporizador_jogador
  import jogador_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: starts the game, learns the first LED, then replays and extends the sequence.
// Build macro JOGADOR_ERRO_EN adds input erro_rodada to corrupt the replay at address 1 in that round.
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int INIT_CYCLES  = 10,
  parameter int PRESS_CYCLES = 10,
  parameter int GAP_CYCLES   = 10,
  parameter int LED_TIMEOUT  = 4000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic [3:0] leds,
  input  logic       ganhou,
  input  logic       perdeu,
`ifdef JOGADOR_ERRO_EN
  input  logic [3:0] erro_rodada,
`endif
  output logic       iniciar,
  output logic [3:0] botoes,
  output logic       concluido,
  output logic       venceu,
  output logic       erro,
  output logic [3:0] db_estado,
  output logic [3:0] db_rodada
);

  // Timer is loaded with N-1 so a state lasts exactly N cycles.
  localparam logic [TIMER_W-1:0] INIT_LOAD  = TIMER_W'(INIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PRESS_LOAD = TIMER_W'(PRESS_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LED_LOAD   = TIMER_W'(LED_TIMEOUT - 1);

  estado_t           state_q, state_d;
  logic [ADDR_W-1:0] rodada_q, rodada_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic              fase_q, fase_d;
  logic              venceu_q, venceu_d;
  logic              iniciar_q, concluido_q, erro_q;
  logic [3:0]        botoes_q, botoes_d;

  logic [3:0]        mem_q [MEM_DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wdata;

  logic               timer_load, timer_done;
  logic [TIMER_W-1:0] timer_value;

  logic       fim_forcado, leds_onehot, corrompe;
  logic [3:0] mem_move, replay_move;

  temporizador_jogador #(.W(TIMER_W)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load_i  (timer_load),
    .value_i (timer_value),
    .done_o  (timer_done)
  );

  assign fim_forcado = (ganhou || perdeu) &&
                       !(state_q inside {INICIAL, INICIA, FIM, ERRO});
  assign leds_onehot = (leds & (leds - 4'd1)) == 4'd0;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    rodada_d    = rodada_q;
    endereco_d  = endereco_q;
    lfsr_d      = lfsr_q;
    fase_d      = fase_q;
    venceu_d    = venceu_q;
    mem_we      = 1'b0;
    mem_addr    = rodada_q;
    mem_wdata   = leds;
    timer_load  = 1'b0;
    timer_value = '0;

    if (fim_forcado) begin
      state_d  = FIM;
      venceu_d = ganhou & ~perdeu;
    end else begin
      unique case (state_q)
        INICIAL: if (habilitar) begin
          state_d     = INICIA;
          timer_load  = 1'b1;
          timer_value = INIT_LOAD;
        end
        INICIA: if (timer_done) begin
          state_d     = ESPERA_LED;
          timer_load  = 1'b1;
          timer_value = LED_LOAD;
        end
        ESPERA_LED: begin
          if (leds != 4'd0) begin
            if (leds_onehot) begin
              state_d   = ESPERA_APAGA;
              mem_we    = 1'b1;
              mem_addr  = '0;
              mem_wdata = leds;
            end else begin
              state_d = ERRO;
            end
          end else if (timer_done) begin
            state_d = ERRO;
          end
        end
        ESPERA_APAGA: if (leds == 4'd0) begin
          rodada_d    = 4'd1;
          endereco_d  = '0;
          state_d     = PRESSIONA;
          timer_load  = 1'b1;
          timer_value = PRESS_LOAD;
        end
        PRESSIONA: if (timer_done) begin
          state_d     = SOLTA;
          timer_load  = 1'b1;
          timer_value = GAP_LOAD;
        end
        SOLTA: if (timer_done) begin
          timer_load  = 1'b1;
          timer_value = PRESS_LOAD;
          if (endereco_q < rodada_q - 4'd1) begin
            endereco_d = endereco_q + 4'd1;
            state_d    = PRESSIONA;
          end else begin
            state_d   = NOVA;
            fase_d    = 1'b0;
            lfsr_d    = lfsr_step(lfsr_q);
            mem_we    = 1'b1;
            mem_addr  = rodada_q;
            mem_wdata = onehot(lfsr_d[1:0]);
          end
        end
        NOVA: if (timer_done) begin
          timer_load = 1'b1;
          if (!fase_q) begin
            fase_d      = 1'b1;
            timer_value = GAP_LOAD;
          end else begin
            rodada_d    = (rodada_q == RODADA_MAX) ? RODADA_MAX : rodada_q + 4'd1;
            endereco_d  = '0;
            state_d     = PRESSIONA;
            timer_value = PRESS_LOAD;
          end
        end
        FIM, ERRO: if (!habilitar) state_d = INICIAL;
        default: state_d = INICIAL;
      endcase
    end
  end

`ifdef JOGADOR_ERRO_EN
  assign corrompe = (erro_rodada != 4'd0) && (rodada_d == erro_rodada) &&
                    (endereco_d == 4'd1);
`else
  assign corrompe = 1'b0;
`endif

  assign mem_move    = mem_q[endereco_d];
  assign replay_move = corrompe ? {mem_move[2:0], mem_move[3]} : mem_move;

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    botoes_d = 4'd0;
    if (state_d == PRESSIONA) begin
      botoes_d = replay_move;
    end else if (state_d == NOVA && !fase_d) begin
      botoes_d = onehot(lfsr_d[1:0]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= INICIAL;
      rodada_q    <= '0;
      endereco_q  <= '0;
      lfsr_q      <= LFSR_SEED;
      fase_q      <= 1'b0;
      venceu_q    <= 1'b0;
      iniciar_q   <= 1'b0;
      botoes_q    <= 4'd0;
      concluido_q <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rodada_q    <= rodada_d;
      endereco_q  <= endereco_d;
      lfsr_q      <= lfsr_d;
      fase_q      <= fase_d;
      venceu_q    <= venceu_d;
      iniciar_q   <= (state_d == INICIA);
      botoes_q    <= botoes_d;
      concluido_q <= (state_d == FIM);
      erro_q      <= (state_d == ERRO);
    end
  end

  // NOTE: the move memory has no reset; only entries written this game are ever read.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  assign iniciar   = iniciar_q;
  assign botoes    = botoes_q;
  assign concluido = concluido_q;
  assign venceu    = venceu_q;
  assign erro      = erro_q;
  assign db_estado = state_q;
  assign db_rodada = rodada_q;

endmodule
